regfile_mp_sb: RTL
==================

# regfile_mp_sb

Parametrised multi-port integer register file with two write ports, same-cycle write-to-read bypass and a per-register busy scoreboard. It sits between the decode/issue stage and the writeback stage of the core. Decode reads operands and busy flags and marks destinations busy at issue; the ALU and load writebacks retire results and clear busy. It is the successor of the single-write, negedge-write register port.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, 4..64
- AW, $clog2(NREGS), address width (derived, not overridden)
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy
- BYPASS, 1, when 1 same-cycle writes forward to read data

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we0 / wa0 / wd0  in  1 / AW / XLEN  write port 0 (ALU writeback)
- we1 / wa1 / wd1  in  1 / AW / XLEN  write port 1 (load writeback)
- ra  in  NRD*AW  packed read addresses; port k = ra[k*AW +: AW]
- rd  out  NRD*XLEN  packed read data
- rbusy  out  NRD  busy flag of each read address
- iss_v  in  1  issue strobe: mark iss_a busy
- iss_a  in  AW  destination address being issued
- wr_conflict  out  1  registered sticky flag: both write ports hit the same non-zero address in one cycle

## Operation
- Storage: NREGS x XLEN array, written on posedge clk. While rst is low, all entries are 0, all busy bits are 0 and wr_conflict is 0.
- Write port qualification: a write is effective iff weN=1 and, when ZERO_REG=1, waN != 0.
- Write collision: when both ports are effective on the same address, wd1 is stored, and wr_conflict sets and holds until reset.
- Read, combinational, for each port k, in priority order:
  1. ZERO_REG=1 and ra_k=0 -> 0.
  2. BYPASS=1 and effective port 1 matches ra_k -> wd1.
  3. BYPASS=1 and effective port 0 matches ra_k -> wd0.
  4. Otherwise -> stored array value.
- Scoreboard, NREGS busy bits, updated on posedge clk:
  - An effective write to address a clears busy[a].
  - An iss_v to address a sets busy[a].
  - Set wins over clear on the same address in the same cycle, because the new producer supersedes the old one.
  - iss_v with address 0 has no effect when ZERO_REG=1.
- rbusy_k = busy[ra_k] AND NOT (BYPASS=1 and an effective write to ra_k this cycle). A result being written is treated as available.
- A write to a non-busy register is legal: it stores data and leaves busy at 0.
- Reset mid-operation: all state clears immediately; any in-flight writes are lost.

## Timing
- Write latency: data is visible from the array on the cycle after the write edge. With BYPASS=1 it is visible on rd in the same cycle, combinationally.
- Issue to busy: rbusy rises the cycle after the iss_v edge, with no bypass on issue.
- Reset values: rd = 0 for every port (array all zero), rbusy = 0, wr_conflict = 0.
- The critical path is ra -> bypass compare -> rd mux. No pipeline registers on reads.

## Test plan
- Reset then read: assert rst=0 mid-run with x5=0x1234 stored -> rd reads x5=0 immediately, rbusy=0, wr_conflict=0.
- Write and bypass (BYPASS=1): we0, wa0=3, wd0=0xDEADBEEF with ra0=3 in the same cycle -> rd0=0xDEADBEEF in that cycle. Next cycle with we0=0 -> rd0=0xDEADBEEF from the array. Repeat with BYPASS=0 -> old value in the write cycle.
- Zero register: we1, wa1=0, wd1=0xFFFFFFFF, plus iss_v with iss_a=0 -> rd for ra=0 is 0 and rbusy=0 on all following cycles.
- Dual-write collision: we0 and we1 both to address 7 with wd0=0x11 and wd1=0x22 -> array holds 0x22 and wr_conflict=1 from the next cycle until reset.
- Scoreboard: iss_v to x9 -> rbusy=1 next cycle. Then we0 to x9 with a concurrent iss_v to x9 -> data stored, busy stays 1. Then a lone we1 to x9 -> rbusy=0 in the write cycle via bypass, and 0 from the array afterwards.
- Parameter sweep: NREGS=16, NRD=4, XLEN=64 -> write distinct 64-bit patterns to all 15 non-zero registers, read all four ports simultaneously, every value matches.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write ports, same-cycle
// write-to-read bypass and a per-register busy scoreboard.
// Write port 1 (load writeback) takes priority over write port 0
// (ALU writeback), both for storage and for forwarding.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we0,
  input  logic [AW-1:0]       i_wa0,
  input  logic [XLEN-1:0]     i_wd0,
  input  logic                i_we1,
  input  logic [AW-1:0]       i_wa1,
  input  logic [XLEN-1:0]     i_wd1,
  input  logic [NRD*AW-1:0]   i_ra,
  output logic [NRD*XLEN-1:0] o_rd,
  output logic [NRD-1:0]      o_rbusy,
  input  logic                i_iss_v,
  input  logic [AW-1:0]       i_iss_a,
  output logic                o_wr_conflict
);

  localparam logic [NREGS-1:0] ONE_HOT0 = NREGS'(1);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_conflict;

  logic             w_wr0;
  logic             w_wr1;
  logic             w_iss;
  logic             w_collide;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;

  // A write or issue to register 0 is discarded when it is hardwired to zero.
  assign w_wr0     = i_we0   && !(ZERO_REG && (i_wa0   == '0));
  assign w_wr1     = i_we1   && !(ZERO_REG && (i_wa1   == '0));
  assign w_iss     = i_iss_v && !(ZERO_REG && (i_iss_a == '0));
  assign w_collide = w_wr0 && w_wr1 && (i_wa0 == i_wa1);

  assign w_clr = ({NREGS{w_wr0}} & (ONE_HOT0 << i_wa0))
               | ({NREGS{w_wr1}} & (ONE_HOT0 << i_wa1));
  assign w_set = {NREGS{w_iss}} & (ONE_HOT0 << i_iss_a);

  // Storage update; the later port-1 assignment wins on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr0) r_mem[i_wa0] <= i_wd0;
      if (w_wr1) r_mem[i_wa1] <= i_wd1;
    end
  end

  // Scoreboard: a new producer (issue) supersedes a retiring one (write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  // Sticky collision flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict <= 1'b0;
    end else if (w_collide) begin
      r_conflict <= 1'b1;
    end
  end

  assign o_wr_conflict = r_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_rd;
      logic            w_busy;

      assign w_ra = i_ra[gi*AW +: AW];

      // Read mux, lowest priority first: array, port 0 bypass, port 1 bypass, zero register.
      always_comb begin
        w_rd   = r_mem[w_ra];
        w_busy = r_busy[w_ra];
        if (BYPASS && w_wr0 && (i_wa0 == w_ra)) begin
          w_rd   = i_wd0;
          w_busy = 1'b0;
        end
        if (BYPASS && w_wr1 && (i_wa1 == w_ra)) begin
          w_rd   = i_wd1;
          w_busy = 1'b0;
        end
        if (ZERO_REG && (w_ra == '0)) begin
          w_rd   = '0;
          w_busy = 1'b0;
        end
      end

      assign o_rd[gi*XLEN +: XLEN] = w_rd;
      assign o_rbusy[gi]           = w_busy;
    end
  endgenerate

endmodule
